// File: rtl/reg_scan_pkg.sv
// Shared types and constants for the register-scan display: digit states,
// blanking values and the active-low hex glyph table.
package reg_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Scan order is D3 -> D2 -> D1 -> D0 -> D3; reset parks in D0.
    typedef enum logic [1:0] {
        D3,
        D2,
        D1,
        D0
    } digit_e;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    function automatic digit_e nextDigit(input digit_e d);
        digit_e n;
        n = D3;
        unique case (d)
            D3: n = D2;
            D2: n = D1;
            D1: n = D0;
            D0: n = D3;
            default: n = D3;
        endcase
        return n;
    endfunction

    // Active-low anode pattern; an[3] is the leftmost digit.
    function automatic logic [3:0] anFor(input digit_e d);
        logic [3:0] a;
        a = AN_OFF;
        unique case (d)
            D3: a = 4'b0111;
            D2: a = 4'b1011;
            D1: a = 4'b1101;
            D0: a = 4'b1110;
            default: a = AN_OFF;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex7seg
    import reg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/reg_scan_display.sv
// Scans mirrored register pairs of the bank and shows addrRa/dataA/addrRb/dataB
// on a 4-digit multiplexed display. Define SCAN_AUTO_EN to enable auto stepping.
module reg_scan_display
    import reg_scan_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned STEP_DIV    = 1000,
    parameter int unsigned NUM_REGS    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       hold,
    input  logic [3:0] datOutRa,
    input  logic [3:0] datOutRb,
    output logic [3:0] addrRa,
    output logic [3:0] addrRb,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int unsigned PW        = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [3:0] K_LAST     = 4'(NUM_REGS / 2 - 1);
    localparam logic [3:0] REG_LAST   = 4'(NUM_REGS - 1);

    logic [PW-1:0] pcnt;
    logic          tick;
    logic          stepQ;
    logic          stepEdge;
    logic          autoWrap;
    logic          advance;
    logic [3:0]    kNext;
    logic [3:0]    shA;
    logic [3:0]    shB;
    logic [3:0]    nibble;
    logic [6:0]    glyph;
    digit_e        stateQ;
    digit_e        stateD;

    // Refresh prescaler
    assign tick = (pcnt == PCNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Manual step edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stepQ <= 1'b0;
        end else begin
            stepQ <= step;
        end
    end

    assign stepEdge = step & ~stepQ;

`ifdef SCAN_AUTO_EN
    localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SW-1:0] SCNT_LAST = SW'(STEP_DIV - 1);

    logic [SW-1:0] scnt;

    assign autoWrap = tick & ~hold & (scnt == SCNT_LAST);

    // A manual edge restarts the auto interval so the two never double-step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt <= '0;
        end else if (stepEdge || autoWrap) begin
            scnt <= '0;
        end else if (tick && !hold) begin
            scnt <= scnt + SW'(1);
        end
    end
`else
    logic unusedCfg;

    assign autoWrap  = 1'b0;
    assign unusedCfg = hold ^ (STEP_DIV == 0);
`endif

    assign advance = stepEdge | autoWrap;
    assign kNext   = (addrRa == K_LAST) ? 4'd0 : addrRa + 4'd1;

    // addrRa doubles as the pair index k; addrRb is its mirror.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrRa <= 4'd0;
            addrRb <= REG_LAST;
        end else if (advance) begin
            addrRa <= kNext;
            addrRb <= REG_LAST - kNext;
        end
    end

    // Sample the bank's asynchronous read data only at slot boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shA <= 4'd0;
            shB <= 4'd0;
        end else if (tick) begin
            shA <= datOutRa;
            shB <= datOutRb;
        end
    end

    // Digit FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= D0;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        if (tick) begin
            stateD = nextDigit(stateQ);
        end
    end

    // Nibble for the digit being entered
    always_comb begin
        nibble = addrRa;
        unique case (stateD)
            D3: nibble = addrRa;
            D2: nibble = shA;
            D1: nibble = addrRb;
            D0: nibble = shB;
            default: nibble = addrRa;
        endcase
    end

    hex7seg uHex7seg (
        .nibble (nibble),
        .seg    (glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (tick) begin
            an  <= anFor(stateD);
            seg <= glyph;
        end
    end

endmodule

// File: tb/tb_reg_scan_display.sv
// Scoreboard bench for reg_scan_display with a behavioural bank reg[i] = 15-i.
module tb_reg_scan_display;

    localparam int unsigned REFRESH_DIV = 4;
    localparam int unsigned STEP_DIV    = 2;
    localparam int unsigned NUM_REGS    = 8;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       step = 1'b0;
    logic       hold = 1'b1;
    logic [3:0] datOutRa;
    logic [3:0] datOutRb;
    logic [3:0] addrRa;
    logic [3:0] addrRb;
    logic [3:0] an;
    logic [6:0] seg;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } dispExp_t;

    typedef struct {
        logic [3:0] ra;
        logic [3:0] rb;
        int         gap;
    } addrExp_t;

    dispExp_t dispQ[$];
    addrExp_t addrQ[$];
    bit       dispEn = 1'b0;
    bit       addrEn = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign datOutRa = 4'hF - addrRa;
    assign datOutRb = 4'hF - addrRb;

    reg_scan_display #(
        .REFRESH_DIV (REFRESH_DIV),
        .STEP_DIV    (STEP_DIV),
        .NUM_REGS    (NUM_REGS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .hold     (hold),
        .datOutRa (datOutRa),
        .datOutRb (datOutRb),
        .addrRa   (addrRa),
        .addrRb   (addrRb),
        .an       (an),
        .seg      (seg)
    );

    function automatic logic [6:0] tbGlyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
            4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
            4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
            4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
        endcase
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tickClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushDisp(input logic [3:0] a, input logic [3:0] nib);
        dispQ.push_back('{an: a, seg: tbGlyph(nib)});
    endtask

    task automatic pushAddr(input logic [3:0] ra, input logic [3:0] rb, input int gap);
        addrExp_t e;
        e.ra  = ra;
        e.rb  = rb;
        e.gap = gap;
        addrQ.push_back(e);
    endtask

    task automatic pushFrame(input logic [3:0] ra, input logic [3:0] rb);
        pushDisp(4'b0111, ra);
        pushDisp(4'b1011, 4'hF - ra);
        pushDisp(4'b1101, rb);
        pushDisp(4'b1110, 4'hF - rb);
    endtask

    task automatic pulseStep(input int highCycles);
        step = 1'b1;
        tickClk(highCycles);
        step = 1'b0;
        tickClk(1);
    endtask

    task automatic waitAn(input logic [3:0] target);
        int n;
        n = 0;
        do begin
            tickClk(1);
            n++;
        end while (an !== target && n < 40);
        if (an !== target) begin
            nTests++;
            nFail++;
            $display("FAIL wait an=%b: timed out with an=%b", target, an);
        end
    endtask

    // Monitor: pops and compares whenever the display digit or the address pair changes.
    logic [3:0] prevAn   = 4'hF;
    logic [7:0] prevAddr = 8'h07;
    int         lastChg  = 0;
    dispExp_t   de;
    addrExp_t   ae;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (an !== prevAn) begin
                if (dispEn) begin
                    if (dispQ.size() == 0) begin
                        nTests++;
                        nFail++;
                        $display("FAIL disp unexpected: an=%b seg=%b, none expected", an, seg);
                    end else begin
                        de = dispQ.pop_front();
                        check("disp an", {28'd0, an}, {28'd0, de.an});
                        check("disp seg", {25'd0, seg}, {25'd0, de.seg});
                    end
                end
                prevAn = an;
            end
            if ({addrRa, addrRb} !== prevAddr) begin
                if (addrEn) begin
                    if (addrQ.size() == 0) begin
                        nTests++;
                        nFail++;
                        $display("FAIL addr unexpected: addrRa=%0h addrRb=%0h, none expected",
                                 addrRa, addrRb);
                    end else begin
                        ae = addrQ.pop_front();
                        check("addrRa seq", {28'd0, addrRa}, {28'd0, ae.ra});
                        check("addrRb seq", {28'd0, addrRb}, {28'd0, ae.rb});
                        if (ae.gap != 0) begin
                            check("addr step period", cyc - lastChg, ae.gap);
                        end
                    end
                end
                prevAddr = {addrRa, addrRb};
                lastChg  = cyc;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state
        tickClk(3);
        check("reset an", an, 4'hF);
        check("reset seg", seg, 7'h7F);
        check("reset addrRa", addrRa, 4'd0);
        check("reset addrRb", addrRb, 4'd7);

        // First lit digit and two steady frames at k=0 (hold keeps auto builds frozen)
        pushFrame(4'd0, 4'd7);
        pushFrame(4'd0, 4'd7);
        dispEn = 1'b1;
        addrEn = 1'b1;
        rst    = 1'b0;
        tickClk(3);
        check("an before first tick", an, 4'hF);
        tickClk(1);
        check("first digit an", an, 4'b0111);
        check("first digit seg", seg, 7'h40);
        tickClk(30);
        dispEn = 1'b0;
        check("frame k=0 drained", dispQ.size(), 0);

        // Step held high gives one advance, one clock after the edge
        pushAddr(4'd1, 4'd6, 0);
        step = 1'b1;
        tickClk(1);
        check("step latency", addrRa, 4'd1);
        tickClk(19);
        step = 1'b0;
        tickClk(2);
        check("held step single advance", addrRa, 4'd1);

        // Display at k=2: D2 shows reg[2]=D, D0 shows reg[5]=A
        pushAddr(4'd2, 4'd5, 0);
        pulseStep(3);
        tickClk(8);
        waitAn(4'b1110);
        waitAn(4'b0111);
        pushDisp(4'b0111, 4'h2);
        pushDisp(4'b1011, 4'hD);
        pushDisp(4'b1101, 4'h5);
        pushDisp(4'b1110, 4'hA);
        dispEn = 1'b1;
        tickClk(14);
        dispEn = 1'b0;
        check("frame k=2 drained", dispQ.size(), 0);

        // Manual wrap 3 -> 0, then up to 3 again
        pushAddr(4'd3, 4'd4, 0);
        pushAddr(4'd0, 4'd7, 0);
        pushAddr(4'd1, 4'd6, 0);
        pushAddr(4'd2, 4'd5, 0);
        pushAddr(4'd3, 4'd4, 0);
        for (int i = 0; i < 5; i++) pulseStep(2);
        check("manual wrap drained", addrQ.size(), 0);

        // Asynchronous reset in slot D1 at k=3, between clock edges
        waitAn(4'b1110);
        waitAn(4'b1101);
        check("pre-reset addrRa", addrRa, 4'd3);
        pushAddr(4'd0, 4'd7, 0);
        #2 rst = 1'b1;
        #1;
        check("async reset an", an, 4'hF);
        check("async reset seg", seg, 7'h7F);
        check("async reset addrRa", addrRa, 4'd0);
        check("async reset addrRb", addrRb, 4'd7);
        tickClk(2);
        check("async reset drained", addrQ.size(), 0);

`ifndef SCAN_AUTO_EN
        // Manual-only build: hold is ignored and nothing advances on its own
        hold = 1'b0;
        rst  = 1'b0;
        tickClk(200);
        check("no auto step addrRa", addrRa, 4'd0);
        pushAddr(4'd1, 4'd6, 0);
        pulseStep(1);
        check("manual only step", addrRa, 4'd1);
        pushAddr(4'd2, 4'd5, 0);
        pulseStep(5);
        check("manual only step 2", addrRb, 4'd5);
        tickClk(20);
        check("manual only drained", addrQ.size(), 0);
`else
        // Auto stepping: 0,1,2,3,0,1 every STEP_DIV*REFRESH_DIV = 8 cycles
        hold = 1'b0;
        pushAddr(4'd1, 4'd6, 0);
        pushAddr(4'd2, 4'd5, 8);
        pushAddr(4'd3, 4'd4, 8);
        pushAddr(4'd0, 4'd7, 8);
        pushAddr(4'd1, 4'd6, 8);
        rst = 1'b0;
        tickClk(7);
        check("auto before first wrap", addrRa, 4'd0);
        tickClk(1);
        check("auto first wrap", addrRa, 4'd1);
        tickClk(36);
        check("auto seq drained", addrQ.size(), 0);

        // Hold freezes auto stepping
        hold = 1'b1;
        tickClk(40);
        check("hold freezes addrRa", addrRa, 4'd1);

        // Step edge on the same edge as an auto wrap advances once
        pushAddr(4'd0, 4'd7, 0);
        rst = 1'b1;
        tickClk(2);
        hold = 1'b0;
        pushAddr(4'd1, 4'd6, 0);
        pushAddr(4'd2, 4'd5, 8);
        pushAddr(4'd3, 4'd4, 8);
        rst = 1'b0;
        tickClk(15);
        step = 1'b1;
        tickClk(1);
        check("step on wrap single", addrRa, 4'd2);
        tickClk(8);
        check("auto after coincide", addrRa, 4'd3);
        step = 1'b0;
        tickClk(2);
        check("coincide drained", addrQ.size(), 0);
`endif

        addrEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
